// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access unit.
package dmem_pkg;

  localparam int TO_W = 8;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  function automatic logic isAligned(input logic [31:0] a);
    return (a[1:0] & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/dmem_timeout_ctr.sv
// Wait-cycle counter for a pending bus request; hit flags the last permitted cycle.
module dmem_timeout_ctr
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam logic [TO_W-1:0] HIT_VAL = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == HIT_VAL);

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data access controller: turns an EX/MEM load/store into a
// req/ready bus transaction, stalling the pipeline until it retires.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        access_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  dmem_state_t state, nextState;

  logic acc;
  logic ctrClr, ctrEn, ctrHit;
  logic startReq;
  logic loadBus, loadZero, finishRead, errSet;

  assign acc = mem_read | mem_write;

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ctrClr),
    .en   (ctrEn),
    .hit  (ctrHit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // bus_ready beats a same-cycle timeout; a write wins over a read in IDLE.
  always_comb begin
    nextState  = state;
    ctrClr     = 1'b0;
    ctrEn      = 1'b0;
    startReq   = 1'b0;
    loadBus    = 1'b0;
    loadZero   = 1'b0;
    finishRead = 1'b0;
    errSet     = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          if (isAligned(addr)) begin
            nextState = REQ;
            ctrClr    = 1'b1;
            startReq  = 1'b1;
          end else begin
            nextState  = DONE;
            errSet     = 1'b1;
            loadZero   = ~mem_write;
            finishRead = ~mem_write;
          end
        end
      end
      REQ: begin
        if (bus_ready) begin
          nextState  = DONE;
          loadBus    = ~bus_we;
          finishRead = ~bus_we;
        end else if (ctrHit) begin
          nextState  = DONE;
          errSet     = 1'b1;
          loadZero   = ~bus_we;
          finishRead = ~bus_we;
        end else begin
          ctrEn = 1'b1;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
    end else begin
      bus_req     <= (nextState == REQ);
      rdata_valid <= finishRead;
      if (errSet) begin
        access_err <= 1'b1;
      end
      if (startReq) begin
        bus_we    <= mem_write;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wdata <= wdata;
      end
      if (loadBus) begin
        rdata <= bus_rdata;
      end else if (loadZero) begin
        rdata <= '0;
      end
    end
  end

  assign stall = rst_n & (((state == IDLE) & acc) | (state == REQ));

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a load-data scoreboard.
module tb_dmem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        access_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  dmem_access_unit #(.TIMEOUT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .rdata_valid(rdata_valid),
    .access_err (access_err),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_ready  (bus_ready),
    .bus_rdata  (bus_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // scoreboard: every rdata_valid pulse consumes one expected load result
  always @(negedge clk) begin
    if (rst_n && rdata_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL rdata_unexpected: observed %0h expected no pulse", rdata);
      end else begin
        check("rdata_sb", rdata, exp_q.pop_front());
      end
    end
  end

  // driver: issue one access, play the bus, count stall/req/valid cycles
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] wd, input bit give_ready,
                            input int wait_cycles, input logic [31:0] rdv,
                            output int stall_cnt, output int req_cnt, output int valid_cnt);
    bit done;
    int cyc;
    stall_cnt = 0;
    req_cnt   = 0;
    valid_cnt = 0;
    done      = 1'b0;
    cyc       = 0;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    if (rd && !wr) exp_q.push_back((give_ready && a[1:0] == 2'b00) ? rdv : 32'h0);
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (rdata_valid) valid_cnt++;
      if (bus_req) begin
        req_cnt++;
        check("bus_addr", bus_addr, {a[31:2], 2'b00});
        check("bus_wdata", bus_wdata, wd);
        check("bus_we", {31'b0, bus_we}, {31'b0, wr});
        bus_ready = give_ready && (req_cnt - 1 == wait_cycles);
        bus_rdata = bus_ready ? rdv : $urandom;
      end else begin
        bus_ready = 1'b0;
      end
      if (stall) stall_cnt++;
      else done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $error("FAIL access_timeout: observed stall stuck after %0d cycles expected release", cyc);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'b0, stall}, 32'h0);
    check("idle_bus_req", {31'b0, bus_req}, 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int s, r, v;
    logic [31:0] d1, d2;
    rst_n     = 1'b0;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    addr      = 32'h100;
    wdata     = 32'h0;
    bus_ready = 1'b0;
    bus_rdata = 32'h0;

    // reset values; stall gated by rst_n even with a pending load
    #12;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_bus_req", {31'b0, bus_req}, 32'h0);
    check("rst_bus_we", {31'b0, bus_we}, 32'h0);
    check("rst_rdata_valid", {31'b0, rdata_valid}, 32'h0);
    check("rst_access_err", {31'b0, access_err}, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    check("rst_bus_wdata", bus_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // load 0x100, ready on first REQ cycle
    run_access(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 0, 32'hDEADBEEF, s, r, v);
    check("ld_stall", s, 2);
    check("ld_req", r, 1);
    check("ld_valid", v, 1);
    check("ld_rdata", rdata, 32'hDEADBEEF);
    check("ld_err", {31'b0, access_err}, 32'h0);

    // store to 0x204 with 3 wait cycles
    run_access(1'b0, 1'b1, 32'h204, 32'h12345678, 1'b1, 3, 32'h0, s, r, v);
    check("st_stall", s, 5);
    check("st_req", r, 4);
    check("st_valid", v, 0);
    check("st_rdata_held", rdata, 32'hDEADBEEF);
    idle_cycle();

    // back-to-back loads; DONE must not re-issue the first
    d1 = $urandom;
    d2 = $urandom;
    run_access(1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 0, d1, s, r, v);
    check("b2b1_stall", s, 2);
    check("b2b1_req", r, 1);
    run_access(1'b1, 1'b0, 32'hC, 32'h0, 1'b1, 0, d2, s, r, v);
    check("b2b2_stall", s, 2);
    check("b2b2_req", r, 1);
    check("b2b2_valid", v, 1);
    idle_cycle();

    // read and write together: write wins, no load result
    run_access(1'b1, 1'b1, 32'h10, 32'hA5A5_0F0F, 1'b1, $urandom_range(0, 2), 32'h0, s, r, v);
    check("rw_req", r >= 1, 1);
    check("rw_valid", v, 0);
    idle_cycle();

    // misaligned load
    run_access(1'b1, 1'b0, 32'h103, 32'h0, 1'b1, 0, 32'hFFFF_FFFF, s, r, v);
    check("mis_stall", s, 1);
    check("mis_req", r, 0);
    check("mis_valid", v, 1);
    check("mis_rdata", rdata, 32'h0);
    check("mis_err", {31'b0, access_err}, 32'h1);
    idle_cycle();

    // reset during REQ
    mem_read = 1'b1;
    addr     = 32'h80;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_req", {31'b0, bus_req}, 32'h1);
    check("pre_rst_err", {31'b0, access_err}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, bus_req}, 32'h0);
    check("mid_rst_stall", {31'b0, stall}, 32'h0);
    check("mid_rst_err", {31'b0, access_err}, 32'h0);
    mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    d1 = $urandom;
    run_access(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1, d1, s, r, v);
    check("post_rst_stall", s, 3);
    check("post_rst_req", r, 2);
    check("post_rst_valid", v, 1);
    check("post_rst_err", {31'b0, access_err}, 32'h0);
    idle_cycle();

    // timeout with ready held low (TIMEOUT=4)
    run_access(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 0, 32'h0, s, r, v);
    check("to_req", r, 4);
    check("to_stall", s, 5);
    check("to_valid", v, 1);
    check("to_rdata", rdata, 32'h0);
    check("to_err", {31'b0, access_err}, 32'h1);
    idle_cycle();

    check("sb_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_access_unit.md
# dmem_access_unit

Data-memory access controller sitting directly downstream of the EX/MEM pipeline register, in place of the single-cycle data memory of the MEM stage. It turns a load/store from EX/MEM into a multi-cycle req/ready transaction on an external data bus. It holds the pipeline via `stall` until the transaction completes, and presents load data for capture into MEM/WB. It also detects misaligned accesses and bus timeouts and reports them on a sticky error flag.

## Interface
- `TIMEOUT`, default 255: max REQ cycles without `bus_ready` before the access is aborted; range 1..255.
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_read`  in  1  load request from EX/MEM.
- `mem_write`  in  1  store request from EX/MEM.
- `addr`  in  32  byte address (EX/MEM ALU result).
- `wdata`  in  32  store data.
- `stall`  out  1  freeze PC, IF/ID, ID/EX and EX/MEM; combinational.
- `rdata`  out  32  load result, registered, held until the next load completes.
- `rdata_valid`  out  1  one-cycle pulse when `rdata` has been updated by a load.
- `access_err`  out  1  sticky error: misaligned access or timeout; cleared only by reset.
- `bus_req`  out  1  bus request, registered.
- `bus_we`  out  1  1 = write, 0 = read.
- `bus_addr`  out  32  word address, `{addr[31:2],2'b00}`.
- `bus_wdata`  out  32  write data.
- `bus_ready`  in  1  bus completion; sampled only while `bus_req`=1.
- `bus_rdata`  in  32  read data, valid when `bus_ready`=1.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - `acc` = `mem_read | mem_write`.
  - If `acc` and `addr[1:0]==0`:
    - latch `bus_we` = `mem_write`; a write wins when both inputs are set.
    - latch `bus_addr` and `bus_wdata`.
    - clear the timeout counter.
    - go to REQ.
  - If `acc` and the address is misaligned: set `access_err`, set `rdata`=0 on a read, go to DONE. No bus request is issued.
- REQ:
  - `bus_req`=1; `bus_we`, `bus_addr` and `bus_wdata` are held stable.
  - On `bus_ready`=1: capture `bus_rdata` into `rdata` on a read, drop `bus_req`, go to DONE.
  - Otherwise increment the counter. When the count reaches TIMEOUT-1 with no ready: drop `bus_req`, set `access_err`, set `rdata`=0 on a read, go to DONE.
- DONE:
  - `rdata_valid`=1 if the access was a read.
  - `mem_read` and `mem_write` are ignored, so the retiring instruction is not re-issued.
  - Go to IDLE.
- `stall` = `rst_n & ((IDLE & acc) | REQ)`.
- Simultaneous `bus_ready` and timeout on the same cycle: `bus_ready` wins and no error is raised.

## Timing
- Reset values:
  - `bus_req`, `bus_we`, `rdata_valid`, `access_err` = 0.
  - `bus_addr`, `bus_wdata`, `rdata` = 0.
  - State = IDLE; `stall`=0 while `rst_n`=0.
- Aligned access with ready on the first REQ cycle:
  - Cycle 0, IDLE: `stall`=1.
  - Cycle 1, REQ: `bus_req`=1, `stall`=1.
  - Cycle 2, DONE: `stall`=0, `rdata_valid`=1.
  - Minimum cost is two stall cycles; each ready wait cycle adds one.
- Misaligned access: one stall cycle (IDLE), then DONE.
- Timeout: `bus_req` is high for exactly TIMEOUT cycles, then DONE.
- Back-to-back accesses: the next access is recognised in the first IDLE cycle after DONE.
- Reset mid-operation: `bus_req` drops immediately (asynchronously), the access is abandoned, the FSM returns to IDLE and `access_err` clears.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` {IDLE, REQ, DONE}.
  - `TO_W`=8, the counter width.
  - `ALIGN_MASK`=2'b11.
- One sub-module, `dmem_timeout_ctr`: 8-bit counter with `clr`/`en` inputs and a `hit` output when the count reaches TIMEOUT-1.
- The FSM, latches and stall logic stay in the top module.

## Test plan
- Load from 0x100, ready on the first REQ cycle with `bus_rdata`=0xDEADBEEF: `stall` is high for 2 cycles; `rdata`=0xDEADBEEF with a one-cycle `rdata_valid` pulse; `bus_we`=0.
- Store 0x12345678 to 0x204, ready after 3 wait cycles: `bus_req` is high for 4 cycles with `bus_addr`=0x204 and `bus_wdata`=0x12345678 held stable; `stall` is high for 5 cycles; no `rdata_valid` pulse.
- Load from 0x103: no `bus_req`; `access_err`=1; `rdata`=0; `stall` is high for 1 cycle.
- TIMEOUT=4, `bus_ready` held at 0: `bus_req` is high for exactly 4 cycles, then `access_err`=1 and `rdata_valid` pulses with `rdata`=0.
- `rst_n` pulsed low during REQ: `bus_req`, `stall` and `access_err` drop immediately; a following load to 0x0 completes normally.
- Two consecutive loads with ready asserted immediately: two separate `bus_req` transactions occur, and the DONE cycle does not re-issue the first load.
